// File: rtl/zoom_scan_if.sv
// Scan-side bus of the zoom sequencer: coordinate/read-enable to the datapath and
// source RAM, write address/strobe and back-pressure from the output framebuffer.
interface zoom_scan_if;
    logic        wr_ready;
    logic [8:0]  x_out_coord;
    logic [7:0]  y_out_coord;
    logic        r_en;
    logic [16:0] w_addr;
    logic        w_en;

    modport master (
        input  wr_ready,
        output x_out_coord, y_out_coord, r_en, w_addr, w_en
    );

    modport slave (
        output wr_ready,
        input  x_out_coord, y_out_coord, r_en, w_addr, w_en
    );
endinterface

// File: rtl/zoom_scan_controller.sv
// Rasters every output coordinate of the zoomed frame, enables the source-RAM read and
// delays the matching write address/strobe by the RAM read latency, stalling on back-pressure.
module zoom_scan_controller #(
    parameter int IMG_WIDTH_IN  = 160,
    parameter int IMG_HEIGHT_IN = 120,
    parameter int SHIFT_FACTOR  = 1,
    parameter int RAM_LATENCY   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    zoom_scan_if.master scan_if
);
    localparam int         OUT_W      = IMG_WIDTH_IN << SHIFT_FACTOR;
    localparam int         OUT_H      = IMG_HEIGHT_IN << SHIFT_FACTOR;
    localparam logic [8:0] X_LAST     = 9'(OUT_W - 1);
    localparam logic [7:0] Y_LAST     = 8'(OUT_H - 1);
    localparam logic [1:0] FLUSH_LAST = 2'(RAM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE_ST} state_e;

    state_e      state_q, state_d;
    logic [8:0]  x_q, x_d;
    logic [7:0]  y_q, y_d;
    logic [16:0] addr_q, addr_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic [RAM_LATENCY-1:0] vld_q;
    logic [16:0] apipe_q [RAM_LATENCY];

    logic busy, adv, at_last, clear;

    assign busy    = (state_q == RUN) || (state_q == FLUSH);
    assign adv     = busy & scan_if.wr_ready;
    assign at_last = (x_q == X_LAST) && (y_q == Y_LAST);
    // Idle and done cycles keep the counters zeroed so a new frame always starts at (0,0).
    assign clear   = abort_i || (state_q == IDLE) || (state_q == DONE_ST);

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        flush_cnt_d = flush_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = RUN;
            end
            RUN: begin
                if (adv) begin
                    if (at_last) begin
                        state_d = FLUSH;
                    end else begin
                        addr_d = addr_q + 17'd1;
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + 8'd1;
                        end else begin
                            x_d = x_q + 9'd1;
                        end
                    end
                end
            end
            FLUSH: begin
                if (adv) begin
                    if (flush_cnt_q == FLUSH_LAST) state_d = DONE_ST;
                    else                           flush_cnt_d = flush_cnt_q + 2'd1;
                end
            end
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (clear) begin
            x_d         = '0;
            y_d         = '0;
            addr_d      = '0;
            flush_cnt_d = '0;
        end
        if (abort_i) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Valid and address pipes track the source-RAM read latency and advance only with it.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the address pipe is a few flops, not RAM, so it is reset to give a known 0 on W_ADDR.
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) apipe_q[i] <= '0;
        end else if (clear) begin
            vld_q <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) apipe_q[i] <= '0;
        end else if (adv) begin
            vld_q[0]   <= (state_q == RUN);
            apipe_q[0] <= addr_q;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                vld_q[i]   <= vld_q[i-1];
                apipe_q[i] <= apipe_q[i-1];
            end
        end
    end

    assign scan_if.x_out_coord = x_q;
    assign scan_if.y_out_coord = y_q;
    assign scan_if.r_en        = adv;
    assign scan_if.w_addr      = apipe_q[RAM_LATENCY-1];
    assign scan_if.w_en        = vld_q[RAM_LATENCY-1] & adv;
    assign busy_o              = busy;
    assign done_o              = (state_q == DONE_ST);
endmodule

// File: tb/tb_zoom_scan_controller.sv
// Scoreboard bench for zoom_scan_controller on a reduced 10x6 output frame with a 3-cycle RAM.
module tb_zoom_scan_controller;
    localparam int IW = 5;
    localparam int IH = 3;
    localparam int SF = 1;
    localparam int L  = 3;
    localparam int W  = IW << SF;
    localparam int H  = IH << SF;
    localparam int P  = W * H;

    logic clk = 1'b0;
    logic rst_n;
    logic start_i, abort_i;
    logic busy_o, done_o;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [16:0] sb [$];

    zoom_scan_if sif ();

    zoom_scan_controller #(
        .IMG_WIDTH_IN (IW),
        .IMG_HEIGHT_IN(IH),
        .SHIFT_FACTOR (SF),
        .RAM_LATENCY  (L)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start_i),
        .abort_i(abort_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .scan_if(sif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_r_en"}, sif.r_en, 0);
        check({tag, "_w_en"}, sif.w_en, 0);
        check({tag, "_w_addr"}, sif.w_addr, 0);
        check({tag, "_x"}, sif.x_out_coord, 0);
        check({tag, "_y"}, sif.y_out_coord, 0);
    endtask

    // One frame: expected coordinates and write addresses follow from the count of advancing cycles.
    task automatic run_frame(input bit rnd, input int abort_at, input int glitch_at, input bit keep_start);
        int start_cyc, rel, advs, stalls, n_wr, post, first_wr, done_rel;
        bit busy_e, done_e, wen_e, aborted, done_seen, dut_done;
        logic [16:0] exp_addr;

        @(posedge clk); #1;
        start_i    = 1'b1;
        abort_i    = 1'b0;
        sif.wr_ready = 1'b1;
        start_cyc  = cyc;
        advs = 0; stalls = 0; n_wr = 0; post = 0; first_wr = -1; done_rel = -1;
        aborted = 0; done_seen = 0; dut_done = 0;
        sb.delete();
        @(negedge clk);
        check("idle_busy", busy_o, 0);
        check("idle_w_addr", sif.w_addr, 0);
        check("idle_x", sif.x_out_coord, 0);
        rel = 0;

        while (!done_seen && !(aborted && post >= 16) && rel < 2000) begin
            @(posedge clk); #1;
            rel          = cyc - start_cyc;
            start_i      = keep_start || (rel == glitch_at);
            abort_i      = (rel == abort_at);
            sif.wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);

            busy_e = !aborted && (advs < P + L);
            done_e = !aborted && (advs == P + L);
            wen_e  = busy_e && sif.wr_ready && (advs >= L);
            check("busy", busy_o, busy_e);
            check("done", done_o, done_e);
            check("r_en", sif.r_en, busy_e & sif.wr_ready);
            check("w_en", sif.w_en, wen_e);

            if (sif.w_en) begin
                n_wr++;
                if (first_wr < 0) first_wr = rel;
                exp_addr = (sb.size() != 0) ? sb.pop_front() : 17'h1FFFF;
                check("w_addr", sif.w_addr, exp_addr);
            end
            if (busy_e && sif.wr_ready && advs < P) begin
                check("x_coord", sif.x_out_coord, advs % W);
                check("y_coord", sif.y_out_coord, advs / W);
                sb.push_back(17'(advs));
            end
            if (aborted) begin
                check("abort_w_addr", sif.w_addr, 0);
                check("abort_x", sif.x_out_coord, 0);
                check("abort_y", sif.y_out_coord, 0);
            end

            if (done_o && !dut_done) begin
                dut_done = 1;
                done_rel = rel;
            end
            if (done_e) done_seen = 1;
            if (busy_e && !sif.wr_ready) stalls++;
            if (busy_e && sif.wr_ready) advs++;
            if (rel == abort_at) aborted = 1;
            if (aborted) post++;
        end

        start_i = keep_start;
        abort_i = 1'b0;
        check("frame_bounded", rel < 2000, 1);
        if (aborted) begin
            check("abort_no_done", dut_done, 0);
            sb.delete();
        end else begin
            check("done_seen", dut_done, 1);
            check("done_cycle", done_rel, P + L + 1 + stalls);
            check("write_count", n_wr, P);
            check("sb_empty", sb.size(), 0);
            if (!rnd) check("first_write_cycle", first_wr, L + 1);
        end
    endtask

    task automatic reset_mid_frame();
        @(posedge clk); #1;
        start_i = 1'b1;
        sif.wr_ready = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_busy", busy_o, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        sif.wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        run_frame(1'b0, -1, -1, 1'b0);
        run_frame(1'b1, -1, 25, 1'b0);
        run_frame(1'b0, 20, -1, 1'b0);
        run_frame(1'b0, -1, -1, 1'b0);
        run_frame(1'b0, -1, -1, 1'b1);
        run_frame(1'b1, -1, -1, 1'b0);
        reset_mid_frame();
        run_frame(1'b1, -1, 40, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
